// File: rtl/conv_layer_seq.sv
// ---------------------------------------------------------------------------
// conv_layer_seq
//
// Multi-filter, strided convolution layer. It computes K output feature maps
// from a D-channel H x W signed fixed-point image. OW parallel MAC lanes
// produce one output row per pass. Each row takes T = D*F*F MAC cycles and
// one STORE cycle. A start/busy/done handshake sequences the layer.
//
// The image and filter inputs are not registered. They must stay stable
// from start until done.
//
// Optional feature (compile-time macro):
//   CONV_RELU_EN  - when defined, STORE writes negative saturated results
//                   as zero (fused ReLU). Latency is unchanged.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   start       in   one-cycle request to begin a layer pass (ignored
//                    unless idle)
//   image       in   D*H*W elements, flattened [d][y][x], element 0 at MSB
//   filter      in   K*D*F*F elements, flattened [k][d][fy][fx], element 0
//                    at MSB
//   busy        out  high while in MAC or STORE
//   done        out  one-cycle pulse after all K maps are written
//   outputConv  out  K*OH*OW elements, flattened [k][r][c], element 0 at MSB
// ---------------------------------------------------------------------------
module conv_layer_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int K          = 4,
    parameter int S          = 1
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic                                                     start,
    input  logic [D*H*W*DATA_WIDTH-1:0]                              image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]                            filter,
    output logic                                                     busy,
    output logic                                                     done,
    output logic [K*((H-F)/S+1)*((W-F)/S+1)*DATA_WIDTH-1:0]          outputConv
);

    localparam int OH    = (H - F) / S + 1;
    localparam int OW    = (W - F) / S + 1;
    localparam int T     = D * F * F;
    localparam int IMG_N = D * H * W;
    localparam int FLT_N = K * T;
    localparam int OUT_N = K * OH * OW;

    localparam int T_BITS = (T  > 1) ? $clog2(T)  : 1;
    localparam int F_BITS = (F  > 1) ? $clog2(F)  : 1;
    localparam int D_BITS = (D  > 1) ? $clog2(D)  : 1;
    localparam int R_BITS = (OH > 1) ? $clog2(OH) : 1;
    localparam int K_BITS = (K  > 1) ? $clog2(K)  : 1;

    // Part-select bases are sized to the addressed vector so the selects
    // below stay width-exact.
    localparam int IMG_SW = $clog2(IMG_N * DATA_WIDTH);
    localparam int FLT_SW = $clog2(FLT_N * DATA_WIDTH);

    localparam logic [T_BITS-1:0] T_LAST = T_BITS'(T - 1);
    localparam logic [F_BITS-1:0] F_LAST = F_BITS'(F - 1);
    localparam logic [R_BITS-1:0] R_LAST = R_BITS'(OH - 1);
    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(K - 1);

    // Saturation bounds expressed at accumulator width so the comparison
    // against the shifted accumulator is a plain signed compare.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // t is the flat tap index. The (d, fy, fx) counters walk in lock-step
    // with it, so address generation needs no divider.
    logic [T_BITS-1:0] t;
    logic [D_BITS-1:0] tap_d;
    logic [F_BITS-1:0] tap_fy;
    logic [F_BITS-1:0] tap_fx;
    logic [R_BITS-1:0] r;
    logic [K_BITS-1:0] k;

    int                              img_base;
    int                              flt_pos;
    logic [FLT_SW-1:0]               flt_sel;
    logic signed [DATA_WIDTH-1:0]    coef;
    logic signed [DATA_WIDTH-1:0]    lane_result [OW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (t == T_LAST) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                busy = 1'b1;
                if (r == R_LAST && k == K_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = MAC;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The row/filter counters wrap to zero on the final STORE, so they
    // are already at their start values when the block returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t      <= '0;
            tap_d  <= '0;
            tap_fy <= '0;
            tap_fx <= '0;
            r      <= '0;
            k      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        t      <= '0;
                        tap_d  <= '0;
                        tap_fy <= '0;
                        tap_fx <= '0;
                        r      <= '0;
                        k      <= '0;
                    end
                end
                MAC: begin
                    if (t != T_LAST) begin
                        t <= t + 1'b1;
                        if (tap_fx == F_LAST) begin
                            tap_fx <= '0;
                            if (tap_fy == F_LAST) begin
                                tap_fy <= '0;
                                tap_d  <= tap_d + 1'b1;
                            end else begin
                                tap_fy <= tap_fy + 1'b1;
                            end
                        end else begin
                            tap_fx <= tap_fx + 1'b1;
                        end
                    end
                end
                STORE: begin
                    t      <= '0;
                    tap_d  <= '0;
                    tap_fy <= '0;
                    tap_fx <= '0;
                    if (r != R_LAST) begin
                        r <= r + 1'b1;
                    end else begin
                        r <= '0;
                        if (k != K_LAST) begin
                            k <= k + 1'b1;
                        end else begin
                            k <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shared tap addressing. img_base is the flat index of lane 0's pixel.
    // Lane c sits c*S elements further along the same row.
    always_comb begin
        img_base = ((int'(tap_d) * H + int'(r) * S + int'(tap_fy)) * W) + int'(tap_fx);
        flt_pos  = ((int'(k) * D + int'(tap_d)) * F + int'(tap_fy)) * F + int'(tap_fx);
        flt_sel  = FLT_SW'((FLT_N - 1 - flt_pos) * DATA_WIDTH);
        coef     = filter[flt_sel +: DATA_WIDTH];
    end

    for (genvar c = 0; c < OW; c++) begin : g_lane
        logic [IMG_SW-1:0]              pix_sel;
        logic signed [DATA_WIDTH-1:0]   pix;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]    prod_ext;
        logic signed [ACC_WIDTH-1:0]    acc;
        logic signed [ACC_WIDTH-1:0]    shifted;
        logic signed [DATA_WIDTH-1:0]   result;

        assign pix_sel  = IMG_SW'((IMG_N - 1 - img_base - c * S) * DATA_WIDTH);
        assign pix      = image[pix_sel +: DATA_WIDTH];
        assign prod     = pix * coef;
        assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

        // Accumulators clear while idle and on every STORE. Each row
        // therefore starts from zero without a separate clear cycle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc <= '0;
            end else if (state == MAC) begin
                acc <= acc + prod_ext;
            end else begin
                acc <= '0;
            end
        end

        // The shift truncates toward minus infinity. Saturation follows
        // the shift, so it only clips the integer range of the result.
        always_comb begin
            shifted = acc >>> FRAC_BITS;
            result  = shifted[DATA_WIDTH-1:0];
            if (shifted > SAT_MAX) begin
                result = RES_MAX;
            end else if (shifted < SAT_MIN) begin
                result = RES_MIN;
            end
`ifdef CONV_RELU_EN
            if (result[DATA_WIDTH-1]) begin
                result = '0;
            end
`else
`endif
        end

        assign lane_result[c] = result;
    end

    // Each output element owns a register. It loads from its lane only
    // during the STORE of its (k, r) row. Values persist across passes
    // until that row is rewritten.
    for (genvar e = 0; e < OUT_N; e++) begin : g_out
        localparam logic [K_BITS-1:0] EK = K_BITS'(e / (OH * OW));
        localparam logic [R_BITS-1:0] ER = R_BITS'((e / OW) % OH);
        localparam int                EC = e % OW;

        logic signed [DATA_WIDTH-1:0] val;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                val <= '0;
            end else if (state == STORE && k == EK && r == ER) begin
                val <= lane_result[EC];
            end
        end

        assign outputConv[(OUT_N-1-e)*DATA_WIDTH +: DATA_WIDTH] = val;
    end

endmodule

// File: tb/tb_conv_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_seq
//
// Directed bench for conv_layer_seq. Four instances cover different
// geometries:
//   A: D=1 H=W=6 F=3 K=1 S=1  (identity, saturation, handshake)
//   B: D=1 H=W=7 F=3 K=2 S=2  (multi-filter, stride)
//   C: D=3 H=W=4 F=3 K=1 S=1  (multi-channel)
//   R: D=1 H=W=5 F=5 K=2 S=1  (reset mid-pass, T=25)
// Expected values are hand-computed constants in Q8.8.
// ---------------------------------------------------------------------------
module tb_conv_layer_seq;

    logic clk;
    logic reset;
    logic [3:0] startVec;
    wire  [3:0] busyVec;
    wire  [3:0] doneVec;

    logic [36*16-1:0] imgA;
    logic [9*16-1:0]  fltA;
    wire  [16*16-1:0] outA;

    logic [49*16-1:0] imgB;
    logic [18*16-1:0] fltB;
    wire  [18*16-1:0] outB;

    logic [48*16-1:0] imgC;
    logic [27*16-1:0] fltC;
    wire  [4*16-1:0]  outC;

    logic [25*16-1:0] imgR;
    logic [50*16-1:0] fltR;
    wire  [2*16-1:0]  outR;

    int cyc;
    int vectors;
    int miscompares;

    conv_layer_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .D(1), .H(6), .W(6),
                     .F(3), .K(1), .S(1)) dutA (
        .clk(clk), .reset(reset), .start(startVec[0]), .image(imgA), .filter(fltA),
        .busy(busyVec[0]), .done(doneVec[0]), .outputConv(outA));

    conv_layer_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .D(1), .H(7), .W(7),
                     .F(3), .K(2), .S(2)) dutB (
        .clk(clk), .reset(reset), .start(startVec[1]), .image(imgB), .filter(fltB),
        .busy(busyVec[1]), .done(doneVec[1]), .outputConv(outB));

    conv_layer_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .D(3), .H(4), .W(4),
                     .F(3), .K(1), .S(1)) dutC (
        .clk(clk), .reset(reset), .start(startVec[2]), .image(imgC), .filter(fltC),
        .busy(busyVec[2]), .done(doneVec[2]), .outputConv(outC));

    conv_layer_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .D(1), .H(5), .W(5),
                     .F(5), .K(2), .S(1)) dutR (
        .clk(clk), .reset(reset), .start(startVec[3]), .image(imgR), .filter(fltR),
        .busy(busyVec[3]), .done(doneVec[3]), .outputConv(outR));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counts one comparison and reports it if observed differs from expected
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [1023:0] putElem(input logic [1023:0] vec, input int n,
                                              input int idx, input logic [15:0] val);
        logic [9:0] sel;
        sel = 10'((n - 1 - idx) * 16);
        vec[sel +: 16] = val;
        return vec;
    endfunction

    function automatic int elemOf(input logic [1023:0] vec, input int n, input int idx);
        logic [9:0]  sel;
        logic [15:0] e;
        sel = 10'((n - 1 - idx) * 16);
        e   = vec[sel +: 16];
        return int'($signed(e));
    endfunction

    function automatic logic [1023:0] fillConst(input int n, input int v);
        logic [1023:0] res;
        res = '0;
        for (int i = 0; i < n; i++) res = putElem(res, n, i, 16'(v));
        return res;
    endfunction

    function automatic int relu(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic bitOf(input logic [3:0] v, input int which);
        return ((v >> which) & 4'b0001) != 4'b0000;
    endfunction

    task automatic setStart(input int which, input logic val);
        startVec = val ? (4'b0001 << which) : 4'b0000;
    endtask

    // Launches a pass on the given instance from the current negedge and
    // waits for done. It checks busy one cycle after start, the done cycle
    // number, and that done lasts one cycle. With hs set, it also pulses
    // start in cycle 5 and in the done cycle; both pulses must be ignored.
    task automatic applyStimulus(input int which, input int expLat, input bit hs);
        int  s0;
        int  cn;
        int  lat;
        bit  seen;
        setStart(which, 1'b1);
        @(negedge clk);
        setStart(which, 1'b0);
        s0 = cyc;
        checkOutput($sformatf("busy_rise_%0d", which), longint'(bitOf(busyVec, which)), 1);
        seen = 1'b0;
        lat  = 0;
        for (int n = 0; n < 3000; n++) begin
            cn = cyc - s0 + 1;
            if (bitOf(doneVec, which)) begin
                seen = 1'b1;
                lat  = cn;
                break;
            end
            setStart(which, hs && cn == 5);
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput($sformatf("done_timeout_%0d", which), 0, 1);
        end else begin
            checkOutput($sformatf("done_cycle_%0d", which), lat, expLat);
        end
        setStart(which, hs);
        @(negedge clk);
        setStart(which, 1'b0);
        checkOutput($sformatf("done_one_cycle_%0d", which), longint'(bitOf(doneVec, which)), 0);
        checkOutput($sformatf("idle_after_done_%0d", which), longint'(bitOf(busyVec, which)), 0);
    endtask

    initial begin
        int s0;
        int doneCount;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        startVec    = 4'b0000;
        imgA = '0; fltA = '0; imgB = '0; fltB = '0;
        imgC = '0; fltC = '0; imgR = '0; fltR = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", longint'(busyVec), 0);
        checkOutput("rst_done", longint'(doneVec), 0);
        checkOutput("rst_outA_nonzero", longint'(outA != '0), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-pass on R: filter0 all 1.0, filter1 all 2.0, image 1.0
        imgR = 400'(fillConst(25, 256));
        for (int i = 0; i < 50; i++) fltR = 800'(putElem(1024'(fltR), 50, i, (i < 25) ? 16'd256 : 16'd512));
        setStart(3, 1'b1);
        @(negedge clk);
        setStart(3, 1'b0);
        s0 = cyc;
        while (cyc - s0 + 1 < 41) @(negedge clk);
        checkOutput("rst_pre_row0", elemOf(1024'(outR), 2, 0), 6400);
        checkOutput("rst_pre_busy", longint'(bitOf(busyVec, 3)), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_busy", longint'(bitOf(busyVec, 3)), 0);
        checkOutput("rst_mid_done", longint'(bitOf(doneVec, 3)), 0);
        checkOutput("rst_mid_out0", elemOf(1024'(outR), 2, 0), 0);
        checkOutput("rst_mid_out1", elemOf(1024'(outR), 2, 1), 0);
        reset = 1'b0;
        doneCount = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (bitOf(doneVec, 3)) doneCount++;
        end
        checkOutput("rst_no_done", doneCount, 0);

        // Identity on A with handshake pulses, then immediate restart
        for (int i = 0; i < 36; i++) imgA = 576'(putElem(1024'(imgA), 36, i, 16'(i * 256)));
        fltA = 144'(putElem(1024'(0), 9, 4, 16'd256));
        applyStimulus(0, 41, 1'b1);
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                checkOutput($sformatf("ident_r%0d_c%0d", rr, cc),
                            elemOf(1024'(outA), 16, rr * 4 + cc), ((rr + 1) * 6 + cc + 1) * 256);
        applyStimulus(0, 41, 1'b0);
        for (int e = 0; e < 16; e++)
            checkOutput($sformatf("ident_again_%0d", e), elemOf(1024'(outA), 16, e),
                        ((e / 4 + 1) * 6 + e % 4 + 1) * 256);

        // Saturation on A: 127.0 everywhere, then negated image
        imgA = 576'(fillConst(36, 32512));
        fltA = 144'(fillConst(9, 32512));
        applyStimulus(0, 41, 1'b0);
        for (int e = 0; e < 16; e++)
            checkOutput($sformatf("sat_pos_%0d", e), elemOf(1024'(outA), 16, e), 32767);
        imgA = 576'(fillConst(36, -32512));
        applyStimulus(0, 41, 1'b0);
        for (int e = 0; e < 16; e++)
            checkOutput($sformatf("sat_neg_%0d", e), elemOf(1024'(outA), 16, e), relu(-32768));

        // Multi-filter with stride 2 on B
        imgB = 784'(fillConst(49, 256));
        for (int i = 0; i < 18; i++) fltB = 288'(putElem(1024'(fltB), 18, i, (i < 9) ? 16'd256 : 16'hFF80));
        applyStimulus(1, 61, 1'b0);
        for (int e = 0; e < 18; e++)
            checkOutput($sformatf("stride_k%0d_%0d", e / 9, e % 9), elemOf(1024'(outB), 18, e),
                        (e < 9) ? 2304 : relu(-1152));

        // Multi-channel on C: channel d is (d+1).0, filters all 1.0
        for (int i = 0; i < 48; i++) imgC = 768'(putElem(1024'(imgC), 48, i, 16'((i / 16 + 1) * 256)));
        fltC = 432'(fillConst(27, 256));
        applyStimulus(2, 57, 1'b0);
        for (int e = 0; e < 4; e++)
            checkOutput($sformatf("multich_%0d", e), elemOf(1024'(outC), 4, e), 13824);

        // Full uninterrupted pass on R
        applyStimulus(3, 53, 1'b0);
        checkOutput("full_r_k0", elemOf(1024'(outR), 2, 0), 6400);
        checkOutput("full_r_k1", elemOf(1024'(outR), 2, 1), 12800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
